// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit, generalised to XLEN.
// One bit per cycle: shift-add multiply, restoring divide on magnitudes,
// then a one-cycle sign-fix stage.
// Optional macro MULDIV_FAST_MUL_EN: multiply ops use a combinational
// full-width product and skip the iterative CALC phase.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [TAG_W-1:0]    r_tag;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_prod;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [XLEN-1:0]     r_result;
    logic [TAG_W-1:0]    r_tag_out;
`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0]     r_a;
`endif

    // Operand sign treatment and magnitudes at the input
    logic                w_sign_a;
    logic                w_sign_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic [XLEN-1:0]     w_special_res;

    // Decode operand signedness, magnitudes and the early-exit divide cases
    always_comb begin
        w_sign_a   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        w_sign_b   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        w_neg_a    = w_sign_a && a[XLEN-1];
        w_neg_b    = w_sign_b && b[XLEN-1];
        w_abs_a    = w_neg_a ? -a : a;
        w_abs_b    = w_neg_b ? -b : b;
        w_div_zero = op[2] && (b == '0);
        w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? a : '1;
        end else if (w_div_ovf) begin
            w_special_res = op[1] ? '0 : a;
        end
    end

    // Iteration datapath; r_prod holds {rem, quotient/dividend} when dividing
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_sub;
    logic [2*XLEN-1:0]   w_div_next;

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : '0);
        w_mul_next  = {w_mul_sum, r_prod[XLEN-1:1]};
        w_div_shift = r_prod[2*XLEN-1:XLEN-1];
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_sub   = w_div_shift[XLEN-1:0] - r_b;
        w_div_next  = w_div_ge ? {w_div_sub, r_prod[XLEN-2:0], 1'b1}
                               : {w_div_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0]   w_prod_src;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_fix_res;

    // Sign fix and result selection for the FIX cycle
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        w_prod_src = r_op[2] ? r_prod
                             : ({{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, r_b});
`else
        w_prod_src = r_prod;
`endif
        w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod_src : w_prod_src;
        w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
        w_rem_fix  = r_neg_a ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];
        case (r_op)
            3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    // Control FSM with registered busy/done/result/tag outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_tag     <= '0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_b       <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_tag_out <= '0;
`ifdef MULDIV_FAST_MUL_EN
            r_a       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= op;
                        r_tag   <= tag_in;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_b     <= w_abs_b;
                        r_prod  <= {{XLEN{1'b0}}, w_abs_a};
                        r_cnt   <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        r_a     <= w_abs_a;
`endif
                        if (w_div_zero || w_div_ovf) begin
                            r_result  <= w_special_res;
                            r_tag_out <= tag_in;
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!op[2]) begin
                            r_state <= S_FIX;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
`endif
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_prod <= r_op[2] ? w_div_next : w_mul_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result  <= w_fix_res;
                    r_tag_out <= r_tag;
                    r_state   <= S_DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign tag_out = r_tag_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .tag_in  (tag_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .tag_out (tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Present an op for one edge, then scramble inputs to show they are not used
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        tag_in = t;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
        tag_in = 5'($urandom);
    endtask

    // Count edges (accepting edge = 1) until done is seen; bounded
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] t,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int bcnt;
        launch(o, x, y, t);
        wait_done(lat, bcnt);
        check({name, "_result"}, 64'(result), 64'(exp_res));
        check({name, "_tag"},    64'(tag_out), 64'(t));
        check({name, "_lat"},    64'(lat), 64'(exp_lat));
        check({name, "_busy"},   64'(bcnt), 64'(exp_lat - 1));
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcount;
        reset  = 1'b1;
        start  = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        tag_in = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_done",   64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_tag",    64'(tag_out), 64'(0));

        // Multiplies (each next op launches during the previous done cycle)
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, MUL_LAT);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, MUL_LAT);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, MUL_LAT);
        run_op("mul_nn", 3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 5'd5, 32'h0000000F, MUL_LAT);

        // Divides
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2, 5'd6,  32'hFFFFFFFD, DIV_LAT);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2, 5'd7,  32'hFFFFFFFF, DIV_LAT);
        run_op("divu",   3'b101, 32'd100,      32'd7, 5'd8,  32'd14,       DIV_LAT);
        run_op("remu",   3'b111, 32'd100,      32'd7, 5'd9,  32'd2,        DIV_LAT);

        // Special cases
        run_op("div0",   3'b100, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, SPC_LAT);
        run_op("remu0",  3'b111, 32'd5, 32'd0, 5'd11, 32'd5,        SPC_LAT);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, SPC_LAT);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        SPC_LAT);
        run_op("divu_big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,      DIV_LAT);

        // done is a single-cycle pulse
        @(posedge clk);
        #1;
        check("pulse_done", 64'(done), 64'(0));
        check("pulse_busy", 64'(busy), 64'(0));

        // start while busy is ignored
        launch(3'b101, 32'd100, 32'd7, 5'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        op     = 3'b000;
        a      = 32'd6;
        b      = 32'd9;
        tag_in = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ign_result", 64'(result), 64'(14));
        check("ign_tag",    64'(tag_out), 64'(7));
        @(posedge clk);
        #1;
        check("ign_done_after", 64'(done), 64'(0));
        check("ign_busy_after", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of a divide
        launch(3'b100, 32'd100, 32'd7, 5'd9);
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy",   64'(busy), 64'(0));
        check("mid_rst_done",   64'(done), 64'(0));
        check("mid_rst_result", 64'(result), 64'(0));
        check("mid_rst_tag",    64'(tag_out), 64'(0));
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        check("mid_rst_no_done", 64'(dcount), 64'(0));

        run_op("mul_after_rst", 3'b000, 32'd6, 32'd7, 5'd1, 32'd42, MUL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
